// File: rtl/rr_switch_alloc_if.sv
// Switch-allocator bundle: per-input head-of-line requests in, per-output
// crossbar selects and per-input buffer pops out.
interface rr_switch_alloc_if #(
  parameter int PORTS = 2
);
  localparam int DW = $clog2(PORTS);

  logic [PORTS-1:0] req_i;
  logic [DW-1:0]    req_dest_i [PORTS];
  logic [PORTS-1:0] head_i;
  logic [PORTS-1:0] tail_i;
  logic [PORTS-1:0] out_ready_i;
  logic [PORTS-1:0] grant_o;
  logic [DW-1:0]    sel_o [PORTS];
  logic [PORTS-1:0] sel_valid_o;
  logic [PORTS-1:0] locked_o;
  logic             err_o;

  // Request side: input buffers and downstream ready
  modport master (
    output req_i, req_dest_i, head_i, tail_i, out_ready_i,
    input  grant_o, sel_o, sel_valid_o, locked_o, err_o
  );

  // Allocator side
  modport slave (
    input  req_i, req_dest_i, head_i, tail_i, out_ready_i,
    output grant_o, sel_o, sel_valid_o, locked_o, err_o
  );
endinterface

// File: rtl/rr_switch_alloc.sv
// Per-output round-robin switch allocator with wormhole locking.
// Each output independently picks one head flit (round robin from its
// pointer), then stays bound to that input until the tail flit passes.
module rr_switch_alloc #(
  parameter int PORTS = 2
) (
  input logic              clk,
  input logic              rst,
  rr_switch_alloc_if.slave sw
);
  localparam int DW = $clog2(PORTS);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} mode_t;

  logic [PORTS-1:0] w_sel_valid;
  logic [DW-1:0]    w_sel [PORTS];
  logic [PORTS-1:0] w_err;
  logic [PORTS-1:0] w_grant;
  logic             r_err;

  // Index of the k-th input scanned from base, wrapping at PORTS
  // (works for non-power-of-two port counts).
  function automatic logic [DW-1:0] rr_idx(input logic [DW-1:0] base, input int k);
    int s;
    s = int'(32'(base)) + k;
    if (s >= PORTS) s = s - PORTS;
    return DW'(s);
  endfunction

  // Pointer advance after a grant: winner+1 with wrap to 0
  function automatic logic [DW-1:0] next_ptr(input logic [DW-1:0] idx);
    return (idx == DW'(PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_out
    mode_t         r_mode;
    logic [DW-1:0] r_owner;
    logic [DW-1:0] r_ptr;
    logic          w_win_valid;
    logic [DW-1:0] w_win_idx;
    logic          w_win_tail;
    logic          w_err_here;

    // Choose the eligible input for this output and flag protocol errors
    always_comb begin
      w_win_valid = 1'b0;
      w_win_idx   = '0;
      w_err_here  = 1'b0;
      if (r_mode == IDLE) begin
        for (int k = 0; k < PORTS; k++) begin
          if (!w_win_valid && sw.req_i[rr_idx(r_ptr, k)] && sw.head_i[rr_idx(r_ptr, k)] &&
              sw.req_dest_i[rr_idx(r_ptr, k)] == DW'(gi)) begin
            w_win_valid = 1'b1;
            w_win_idx   = rr_idx(r_ptr, k);
          end
        end
        // A body/tail flit aimed at an unowned output has lost its head
        for (int i = 0; i < PORTS; i++) begin
          if (sw.req_i[i] && !sw.head_i[i] && sw.req_dest_i[i] == DW'(gi)) w_err_here = 1'b1;
        end
      end else begin
        // Only the owner may continue; a fresh head from it is a framing error
        if (sw.req_i[r_owner] && sw.req_dest_i[r_owner] == DW'(gi)) begin
          if (sw.head_i[r_owner]) begin
            w_err_here = 1'b1;
          end else begin
            w_win_valid = 1'b1;
            w_win_idx   = r_owner;
          end
        end
      end
      w_win_tail = sw.tail_i[w_win_idx];
    end

    // Transfer only when downstream is ready; reset forces everything quiet
    assign w_sel_valid[gi]  = w_win_valid & sw.out_ready_i[gi] & ~rst;
    assign w_sel[gi]        = w_sel_valid[gi] ? w_win_idx : '0;
    assign w_err[gi]        = w_err_here;
    assign sw.sel_o[gi]     = w_sel[gi];
    assign sw.locked_o[gi]  = (r_mode == LOCKED);

    // Commit pointer / lock state only on an actual transfer
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mode  <= IDLE;
        r_owner <= '0;
        r_ptr   <= '0;
      end else if (w_sel_valid[gi]) begin
        if (r_mode == IDLE) begin
          r_ptr <= next_ptr(w_win_idx);
          if (!w_win_tail) begin
            r_mode  <= LOCKED;
            r_owner <= w_win_idx;
          end
        end else if (w_win_tail) begin
          r_mode <= IDLE;
        end
      end
    end
  end

  // Grant an input when any output selects it; each input names one output
  always_comb begin
    w_grant = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (w_sel_valid[o] && w_sel[o] == DW'(i)) w_grant[i] = 1'b1;
      end
    end
  end

  assign sw.grant_o     = w_grant;
  assign sw.sel_valid_o = w_sel_valid;

  // Error pulse appears the cycle after the offending request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= |w_err;
  end

  assign sw.err_o = r_err;
endmodule

// File: doc/rr_switch_alloc.md
# rr_switch_alloc

Per-output round-robin switch allocator for the NoC router crossbar. It takes per-input head-of-line flit requests (destination port plus head/tail markers) and picks at most one input per output each cycle. It locks an output to its winning input from head flit to tail flit so packets are never interleaved (wormhole switching). Its select/valid outputs drive the crossbar's per-port destination and enable inputs directly, and its grants dequeue the input buffers.

## Interface
- PORTS, 2: number of router ports (inputs = outputs), ≥2, need not be a power of two
- DW = $clog2(PORTS): port-index width (localparam)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- req_i[PORTS]  in  1  input i has a valid flit at buffer head
- req_dest_i[PORTS]  in  DW  output port requested by input i's flit
- head_i[PORTS]  in  1  input i's flit is a head flit
- tail_i[PORTS]  in  1  input i's flit is a tail flit (head&tail = single-flit packet)
- out_ready_i[PORTS]  in  1  output o's downstream can accept a flit this cycle
- grant_o[PORTS]  out  1  input i's flit transfers this cycle (pop buffer)
- sel_o[PORTS]  out  DW  input index routed to output o
- sel_valid_o[PORTS]  out  1  output o transfers a flit this cycle
- locked_o[PORTS]  out  1  output o is mid-packet (registered state)
- err_o  out  1  single-cycle protocol-error pulse (registered)

## Operation
- Per-output state: mode[o] ∈ {IDLE, LOCKED}, owner[o] (DW), ptr[o] (DW, round-robin start index).
- IDLE: candidates are inputs i with req_i & head_i & req_dest_i==o. Winner = first candidate scanning i = ptr[o], ptr[o]+1, … modulo PORTS. If a winner exists and out_ready_i[o]=1: sel_valid_o[o]=1, sel_o[o]=winner, grant_o[winner]=1.
  - On this grant, ptr[o] <= (winner+1) mod PORTS (wraps PORTS-1 -> 0, also for non-power-of-two PORTS).
  - If the winning flit has tail_i=0: mode <= LOCKED, owner <= winner. If tail_i=1: stay IDLE.
- LOCKED: only owner[o] is eligible. A transfer occurs when req_i[owner]=1, req_dest_i[owner]==o, head_i[owner]=0 and out_ready_i[o]=1. ptr is unchanged. A transfer with tail_i=1 returns mode to IDLE.
- Arbitration never considers non-head flits on an IDLE output, or inputs other than the owner on a LOCKED output. These flits are not granted.
- Protocol errors raise err_o the next cycle. No grant is given for the offending flit and state is unchanged:
  - a non-head flit requests an IDLE output with no owner;
  - the owner presents head_i=1 while its output is LOCKED.
- Each input names one destination, so at most one grant_o per input per cycle. The grant vector is consistent with sel_o/sel_valid_o: grant_o[i]=1 iff some o has sel_valid_o[o] and sel_o[o]==i.
- Outputs with sel_valid_o=0 drive sel_o=0.

## Timing
- grant_o, sel_o and sel_valid_o are combinational from the inputs and registered state: zero-cycle allocation latency. Crossbar data moves in the same cycle as the grant.
- mode, owner, ptr and err_o update on the rising clk edge after the transfer.
- Reset value of every output:
  - While rst=1: grant_o=0, sel_valid_o=0, sel_o=0, locked_o=0, err_o=0.
  - Registered state resets to mode=IDLE, owner=0, ptr=0.
  - Asserting rst mid-packet drops all locks immediately. The next packet must start with a head flit.
- Tail transfer and a competing head in the same cycle: the head is not granted that cycle. The output is IDLE from the next cycle, so the earliest re-grant comes one cycle after the tail.
- out_ready_i[o]=0: no grant. In IDLE, ptr and the winner choice are not committed; the winner is re-evaluated each cycle. In LOCKED, the lock is held indefinitely.
- Distinct outputs are fully independent. Up to PORTS transfers per cycle.

## Test plan
- Reset: PORTS=4, assert rst with all req_i=1 -> every output 0. After release, ptr=0 on all outputs (inputs 0 and 2 heads to output 1 -> input 0 granted).
- Round robin: PORTS=4, inputs 0–3 each send single-flit packets (head&tail) to output 2 continuously, out_ready=1 -> grant sequence 0,1,2,3,0. sel_o[2] follows the same sequence. Repeat with PORTS=3 to check wrap 2->0.
- Wormhole lock: input 1 sends a 3-flit packet to output 0 while input 3 holds a head to output 0 -> grants 1,1,1. locked_o[0]=1 for 2 cycles. Input 3 is granted the cycle after the tail.
- Backpressure: lock output 0 to input 2, hold out_ready_i[0]=0 for 5 cycles -> no grants, locked_o[0] stays 1. Ready returns -> body flit is granted.
- Parallel and errors:
  - inputs 0→1, 1→0, 2→3, 3→2 in the same cycle -> all four granted;
  - a body flit (head=0) to an IDLE output -> no grant, err_o=1 for one cycle;
  - rst mid-packet -> locked_o=0 after reset.
